// File: rtl/timekeeper_core.sv
// Real-time clock core: seconds divider, 24-hour BCD time, handshake time load
// through a three-cycle binary-to-BCD conversion, 12/24-hour display and alarm.
module timekeeper_core #(
    parameter int unsigned CLK_HZ   = 50000000,
    parameter int unsigned ALARM_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       mode12,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    input  logic       alarm_we,
    input  logic       alarm_arm,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_ack,
    output logic [3:0] sec_1,
    output logic [2:0] sec_10,
    output logic [3:0] min_1,
    output logic [2:0] min_10,
    output logic [3:0] hour_1,
    output logic [1:0] hour_10,
    output logic       pm,
    output logic       tick,
    output logic       day_pulse,
    output logic       alarm,
    output logic       set_err
);

    localparam int unsigned DIV_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_HZ - 1);

    typedef enum logic [1:0] {IDLE, CONV_S, CONV_M, CONV_H} set_state_t;

    typedef struct packed {
        logic [1:0] h10;
        logic [3:0] h1;
        logic [2:0] m10;
        logic [3:0] m1;
        logic [2:0] s10;
        logic [3:0] s1;
    } bcd_time_t;

    // Inputs never exceed 63, so six subtract-ten steps suffice.
    function automatic logic [6:0] bin2bcd(input logic [6:0] v);
        logic [6:0] r;
        logic [2:0] t;
        r = v;
        t = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (r >= 7'd10) begin
                r = r - 7'd10;
                t = t + 3'd1;
            end
        end
        return {t, r[3:0]};
    endfunction

    set_state_t       state_q, state_d;
    logic [4:0]       pay_h_q, pay_h_d;
    logic [5:0]       pay_m_q, pay_m_d;
    logic [5:0]       pay_s_q, pay_s_d;
    logic [6:0]       conv_s_q, conv_s_d;
    logic [6:0]       conv_m_q, conv_m_d;
    bcd_time_t        time_q, time_d, time_inc;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             day_q, day_d;
    logic             err_q, err_d;
    logic             sec_tick, tick_adv, at_max, set_ok;
    logic [4:0]       hour_bin, disp_hr;

    assign sec_tick = run && (div_q == DIV_MAX);
    // The load edge (leaving CONV_H) swallows any coincident second.
    assign tick_adv = sec_tick && (state_q != CONV_H);
    assign at_max   = (time_q == {2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd9});
    assign set_ok   = (set_hour <= 5'd23) && (set_min <= 6'd59) && (set_sec <= 6'd59);

    always_comb begin
        time_inc = time_q;
        if (time_q.s1 != 4'd9) begin
            time_inc.s1 = time_q.s1 + 4'd1;
        end else begin
            time_inc.s1 = '0;
            if (time_q.s10 != 3'd5) begin
                time_inc.s10 = time_q.s10 + 3'd1;
            end else begin
                time_inc.s10 = '0;
                if (time_q.m1 != 4'd9) begin
                    time_inc.m1 = time_q.m1 + 4'd1;
                end else begin
                    time_inc.m1 = '0;
                    if (time_q.m10 != 3'd5) begin
                        time_inc.m10 = time_q.m10 + 3'd1;
                    end else begin
                        time_inc.m10 = '0;
                        if (time_q.h10 == 2'd2 && time_q.h1 == 4'd3) begin
                            time_inc.h10 = '0;
                            time_inc.h1  = '0;
                        end else if (time_q.h1 == 4'd9) begin
                            time_inc.h10 = time_q.h10 + 2'd1;
                            time_inc.h1  = '0;
                        end else begin
                            time_inc.h1 = time_q.h1 + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        pay_h_d  = pay_h_q;
        pay_m_d  = pay_m_q;
        pay_s_d  = pay_s_q;
        conv_s_d = conv_s_q;
        conv_m_d = conv_m_q;
        time_d   = time_q;
        div_d    = div_q;
        tick_d   = 1'b0;
        day_d    = 1'b0;
        err_d    = 1'b0;

        if (run) div_d = (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
        if (tick_adv) begin
            time_d = time_inc;
            tick_d = 1'b1;
            day_d  = at_max;
        end

        case (state_q)
            IDLE: begin
                if (set_valid) begin
                    if (set_ok) begin
                        pay_h_d = set_hour;
                        pay_m_d = set_min;
                        pay_s_d = set_sec;
                        state_d = CONV_S;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CONV_S: begin
                conv_s_d = bin2bcd({1'b0, pay_s_q});
                state_d  = CONV_M;
            end
            CONV_M: begin
                conv_m_d = bin2bcd({1'b0, pay_m_q});
                state_d  = CONV_H;
            end
            CONV_H: begin
                time_d  = {6'(bin2bcd({2'b00, pay_h_q})), conv_m_q, conv_s_q};
                div_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pay_h_q  <= '0;
            pay_m_q  <= '0;
            pay_s_q  <= '0;
            conv_s_q <= '0;
            conv_m_q <= '0;
            time_q   <= '0;
            div_q    <= '0;
            tick_q   <= 1'b0;
            day_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pay_h_q  <= pay_h_d;
            pay_m_q  <= pay_m_d;
            pay_s_q  <= pay_s_d;
            conv_s_q <= conv_s_d;
            conv_m_q <= conv_m_d;
            time_q   <= time_d;
            div_q    <= div_d;
            tick_q   <= tick_d;
            day_q    <= day_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        hour_bin = 5'(time_q.h10) * 5'd10 + 5'(time_q.h1);
        disp_hr  = hour_bin;
        pm       = 1'b0;
        if (mode12) begin
            if (hour_bin == 5'd0) begin
                disp_hr = 5'd12;
            end else if (hour_bin >= 5'd12) begin
                pm = 1'b1;
                if (hour_bin > 5'd12) disp_hr = hour_bin - 5'd12;
            end
        end
        {hour_10, hour_1} = 6'(bin2bcd({2'b00, disp_hr}));
    end

    assign sec_1     = time_q.s1;
    assign sec_10    = time_q.s10;
    assign min_1     = time_q.m1;
    assign min_10    = time_q.m10;
    assign set_ready = (state_q == IDLE);
    assign tick      = tick_q;
    assign day_pulse = day_q;
    assign set_err   = err_q;

    if (ALARM_EN != 0) begin : g_alarm
        logic [5:0] alm_h_q, alm_h_d;
        logic [6:0] alm_m_q, alm_m_d;
        logic       armed_q, armed_d;
        logic       alarm_q, alarm_d;
        logic       hit;

        // Only a real second advance can match; a time load never fires.
        always_comb begin
            alm_h_d = alm_h_q;
            alm_m_d = alm_m_q;
            armed_d = armed_q;
            alarm_d = alarm_q;
            hit     = armed_q && tick_adv && (time_inc == {alm_h_q, alm_m_q, 7'd0});
            if (alarm_we && (alarm_hour <= 5'd23) && (alarm_min <= 6'd59)) begin
                alm_h_d = 6'(bin2bcd({2'b00, alarm_hour}));
                alm_m_d = bin2bcd({1'b0, alarm_min});
                armed_d = alarm_arm;
            end
            if (hit) alarm_d = 1'b1;
            else if (alarm_ack) alarm_d = 1'b0;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                alm_h_q <= '0;
                alm_m_q <= '0;
                armed_q <= 1'b0;
                alarm_q <= 1'b0;
            end else begin
                alm_h_q <= alm_h_d;
                alm_m_q <= alm_m_d;
                armed_q <= armed_d;
                alarm_q <= alarm_d;
            end
        end

        assign alarm = alarm_q;
    end else begin : g_no_alarm
        assign alarm = 1'b0;
    end

endmodule

// File: tb/tb_timekeeper_core.sv
// Bench for timekeeper_core: time kept as seconds-of-day and the load path as a
// countdown, compared against the DUT every cycle plus directed corner cases.
module tb_timekeeper_core;

    localparam int unsigned CLK_HZ = 4;

    logic       clk = 1'b0;
    logic       rst, run, mode12, set_valid, set_ready;
    logic [4:0] set_hour;
    logic [5:0] set_min, set_sec;
    logic       alarm_we, alarm_arm, alarm_ack;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic [3:0] sec_1, min_1, hour_1;
    logic [2:0] sec_10, min_10;
    logic [1:0] hour_10;
    logic       pm, tick, day_pulse, alarm, set_err;

    always #5 clk = ~clk;

    timekeeper_core #(.CLK_HZ(CLK_HZ), .ALARM_EN(1)) dut (
        .clk(clk), .rst(rst), .run(run), .mode12(mode12),
        .set_valid(set_valid), .set_ready(set_ready),
        .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .alarm_we(alarm_we), .alarm_arm(alarm_arm), .alarm_hour(alarm_hour),
        .alarm_min(alarm_min), .alarm_ack(alarm_ack),
        .sec_1(sec_1), .sec_10(sec_10), .min_1(min_1), .min_10(min_10),
        .hour_1(hour_1), .hour_10(hour_10), .pm(pm), .tick(tick),
        .day_pulse(day_pulse), .alarm(alarm), .set_err(set_err)
    );

    int checks = 0;
    int errors = 0;
    int tick_seen = 0;
    int day_seen = 0;

    // Reference state: seconds of day, divider count, cycles left before load.
    int m_tod, m_div, m_busy, m_pend, m_ah, m_am;
    bit m_armed, m_alarm, m_tick, m_day, m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] disp_of(input int tod, input bit m12);
        int h, m, s, dh;
        bit p;
        h  = tod / 3600;
        m  = (tod / 60) % 60;
        s  = tod % 60;
        dh = h;
        p  = 1'b0;
        if (m12) begin
            p = (h >= 12);
            if (h == 0) dh = 12;
            else if (h > 12) dh = h - 12;
        end
        return {2'(dh / 10), 4'(dh % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10), p};
    endfunction

    function automatic logic [20:0] obs();
        return {hour_10, hour_1, min_10, min_1, sec_10, sec_1, pm};
    endfunction

    task automatic model_step();
        bit fire, hit;
        m_tick = 0;
        m_day  = 0;
        m_err  = 0;
        hit    = 0;
        if (rst) begin
            m_tod = 0; m_div = 0; m_busy = 0;
            m_ah = 0; m_am = 0; m_armed = 0; m_alarm = 0;
        end else begin
            fire = run && (m_div == CLK_HZ - 1);
            if (run) m_div = fire ? 0 : m_div + 1;
            if (m_busy == 1) begin
                m_tod  = m_pend;
                m_div  = 0;
                m_busy = 0;
            end else begin
                if (fire) begin
                    m_tod  = (m_tod + 1) % 86400;
                    m_tick = 1;
                    m_day  = (m_tod == 0);
                    hit    = m_armed && (m_tod == m_ah * 3600 + m_am * 60);
                end
                if (m_busy > 0) begin
                    m_busy--;
                end else if (set_valid) begin
                    if (set_hour > 23 || set_min > 59 || set_sec > 59) begin
                        m_err = 1;
                    end else begin
                        m_pend = set_hour * 3600 + set_min * 60 + set_sec;
                        m_busy = 3;
                    end
                end
            end
            if (hit) m_alarm = 1;
            else if (alarm_ack) m_alarm = 0;
            if (alarm_we && alarm_hour <= 23 && alarm_min <= 59) begin
                m_ah    = alarm_hour;
                m_am    = alarm_min;
                m_armed = alarm_arm;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("display", 32'(obs()), 32'(disp_of(m_tod, mode12)));
        check("tick", 32'(tick), 32'(m_tick));
        check("day_pulse", 32'(day_pulse), 32'(m_day));
        check("set_err", 32'(set_err), 32'(m_err));
        check("set_ready", 32'(set_ready), 32'(m_busy == 0));
        check("alarm", 32'(alarm), 32'(m_alarm));
        if (tick) tick_seen++;
        if (day_pulse) day_seen++;
    endtask

    task automatic do_set(input int h, input int m, input int s);
        set_hour  = 5'(h);
        set_min   = 6'(m);
        set_sec   = 6'(s);
        set_valid = 1'b1;
        step();
        set_valid = 1'b0;
        repeat (3) step();
    endtask

    task automatic write_alarm(input int h, input int m, input bit arm);
        alarm_hour = 5'(h);
        alarm_min  = 6'(m);
        alarm_arm  = arm;
        alarm_we   = 1'b1;
        step();
        alarm_we   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; mode12 = 1'b1; set_valid = 1'b0;
        set_hour = '0; set_min = '0; set_sec = '0;
        alarm_we = 1'b0; alarm_arm = 1'b0; alarm_hour = '0; alarm_min = '0; alarm_ack = 1'b0;
        m_tod = 0; m_div = 0; m_busy = 0; m_pend = 0; m_ah = 0; m_am = 0;
        m_armed = 0; m_alarm = 0; m_tick = 0; m_day = 0; m_err = 0;

        repeat (2) step();
        check("reset_12h_display", 32'(obs()), 32'({2'd1, 4'd2, 3'd0, 4'd0, 3'd0, 4'd0, 1'b0}));
        check("reset_ready", 32'(set_ready), 32'd1);
        rst = 1'b0;

        // Divider cadence, then run=0 freeze
        mode12 = 1'b0; run = 1'b1; tick_seen = 0;
        repeat (12) step();
        check("tick_count_12cyc", 32'(tick_seen), 32'd3);
        check("sec_after_ticks", 32'(sec_1), 32'd3);
        run = 1'b0;
        repeat (10) step();
        check("tick_count_frozen", 32'(tick_seen), 32'd3);
        check("sec_frozen", 32'(sec_1), 32'd3);

        // Midnight wrap after a load
        do_set(23, 59, 58);
        check("loaded_235958", 32'(obs()), 32'({2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd8, 1'b0}));
        run = 1'b1; day_seen = 0;
        repeat (2 * CLK_HZ) step();
        check("midnight", 32'(obs()), 32'd0);
        check("day_pulse_count", 32'(day_seen), 32'd1);

        // Out-of-range loads
        run = 1'b0;
        do_set(24, 0, 0);
        do_set(5, 60, 0);
        do_set(5, 0, 60);
        check("bad_set_unchanged", 32'(obs()), 32'd0);

        // 12-hour display mapping
        do_set(0, 15, 0);
        mode12 = 1'b1; step();
        check("h12_0015", 32'({hour_10, hour_1, pm}), 32'({2'd1, 4'd2, 1'b0}));
        mode12 = 1'b0; step();
        check("h24_0015", 32'({hour_10, hour_1, pm}), 32'({2'd0, 4'd0, 1'b0}));
        do_set(12, 0, 0);
        mode12 = 1'b1; step();
        check("h12_1200", 32'({hour_10, hour_1, pm}), 32'({2'd1, 4'd2, 1'b1}));
        do_set(13, 5, 0);
        step();
        check("h12_1305", 32'({hour_10, hour_1, pm}), 32'({2'd0, 4'd1, 1'b1}));
        mode12 = 1'b0; step();
        check("h24_1305", 32'({hour_10, hour_1, pm}), 32'({2'd1, 4'd3, 1'b0}));

        // Alarm: fire, hold, ack, ack-on-match, load-on-alarm, disarmed
        write_alarm(7, 30, 1'b1);
        run = 1'b1;
        do_set(7, 29, 59);
        repeat (CLK_HZ) step();
        check("alarm_fired", 32'(alarm), 32'd1);
        repeat (6) step();
        check("alarm_held", 32'(alarm), 32'd1);
        alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
        check("alarm_acked", 32'(alarm), 32'd0);
        do_set(7, 29, 59);
        for (int i = 0; i < CLK_HZ + 2; i++) begin
            alarm_ack = (m_div == CLK_HZ - 1);
            step();
        end
        alarm_ack = 1'b0;
        check("alarm_ack_vs_match", 32'(alarm), 32'd1);
        alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
        do_set(7, 30, 0);
        check("load_on_alarm_time", 32'(alarm), 32'd0);
        write_alarm(7, 30, 1'b0);
        do_set(7, 29, 59);
        repeat (2 * CLK_HZ) step();
        check("alarm_disarmed", 32'(alarm), 32'd0);

        // Reset during conversion discards the payload
        set_hour = 5'd9; set_min = 6'd9; set_sec = 6'd9; set_valid = 1'b1;
        step();
        set_valid = 1'b0;
        step();
        rst = 1'b1; step(); rst = 1'b0;
        repeat (6) step();
        check("abort_ready", 32'(set_ready), 32'd1);
        check("abort_no_commit", 32'(obs()), 32'(disp_of(6 / CLK_HZ, 1'b0)));

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            run       = ($urandom_range(0, 9) != 0);
            mode12    = 1'($urandom);
            set_valid = ($urandom_range(0, 24) == 0);
            set_hour  = 5'($urandom_range(0, 25));
            set_min   = 6'($urandom_range(0, 61));
            set_sec   = 6'($urandom_range(0, 61));
            if ($urandom_range(0, 2) == 0) set_sec = 6'($urandom_range(54, 59));
            alarm_we  = ($urandom_range(0, 39) == 0);
            alarm_arm = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0) begin
                alarm_hour = 5'(((m_tod + 60) / 3600) % 24);
                alarm_min  = 6'(((m_tod + 60) / 60) % 60);
            end else begin
                alarm_hour = 5'($urandom_range(0, 24));
                alarm_min  = 6'($urandom_range(0, 61));
            end
            alarm_ack = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
